// File: rtl/dac_spi_tx.sv
// dac_spi_tx: captures dacCount_i on a fixed-rate sample tick and shifts it to an SPI DAC (mode 0, MSB first)
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   dacCount_i  sample from the sound generator (N bits)
//   enable_i    transmit permitted, sampled at the tick
//   sclk_o      SPI clock, idles low
//   mosi_o      SPI data, MSB first, 0 while csN_o is high
//   csN_o       DAC chip select, active low
//   busy_o      high from capture through the deselect gap
//   overrun_o   one-cycle pulse when a tick is dropped because a frame is in flight
//
// Build option: define DAC_SPI_CMD_EN to prepend the 4-bit DAC command header 4'b0111
// (channel A, buffered, gain 1x, active), giving an N+4 bit frame; otherwise the frame is N data bits.
module dac_spi_tx #(
  parameter int N          = 8,
  parameter int CLK_DIV    = 4,
  parameter int SAMPLE_DIV = 1500
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] dacCount_i,
  input  logic         enable_i,
  output logic         sclk_o,
  output logic         mosi_o,
  output logic         csN_o,
  output logic         busy_o,
  output logic         overrun_o
);
`ifdef DAC_SPI_CMD_EN
  localparam int F = N + 4;
`else
  localparam int F = N;
`endif
  localparam int TW = $clog2(SAMPLE_DIV + 1);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(F + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;
  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [DW-1:0] div_q, div_d;
  logic          hi_q, hi_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [F-1:0]  sr_q, sr_d, frame;
  logic          sclk_q, mosi_q, csn_q, busy_q, ovr_q;
  logic          sclk_d, mosi_d, csn_d, busy_d, ovr_d;
  logic          tick, phase_end;
`ifdef DAC_SPI_CMD_EN
  assign frame = {4'b0111, dacCount_i};
`else
  assign frame = dacCount_i;
`endif
  assign tick      = tick_q == TW'(SAMPLE_DIV - 1);
  assign tick_d    = tick ? '0 : tick_q + 1'b1;
  assign phase_end = div_q == DW'(CLK_DIV - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      div_q   <= '0;
      hi_q    <= 1'b0;
      bit_q   <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      div_q   <= div_d;
      hi_q    <= hi_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
    end
  end
  // hi_q selects the sclk phase of the current bit; a bit retires at the end of its high phase
  always_comb begin
    state_d = state_q;
    div_d   = phase_end ? '0 : div_q + 1'b1;
    hi_d    = hi_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    case (state_q)
      IDLE: begin
        div_d = '0;
        if (tick && enable_i) begin
          state_d = SHIFT;
          hi_d    = 1'b0;
          bit_d   = BW'(F - 1);
          sr_d    = frame;
        end
      end
      SHIFT: if (phase_end) begin
        hi_d = !hi_q;
        if (hi_q) begin
          sr_d    = sr_q << 1;
          bit_d   = bit_q - 1'b1;
          state_d = bit_q == '0 ? HOLD : SHIFT;
        end
      end
      HOLD:    state_d = phase_end ? GAP : HOLD;
      GAP:     state_d = phase_end ? IDLE : GAP;
      default: state_d = IDLE;
    endcase
  end
  // outputs are decoded from next state so every pin comes straight from a flop
  always_comb begin
    csn_d  = !(state_d == SHIFT || state_d == HOLD);
    sclk_d = state_d == SHIFT && hi_d;
    mosi_d = state_d == SHIFT && sr_d[F-1];
    busy_d = state_d != IDLE;
    ovr_d  = tick && state_q != IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
      csn_q  <= 1'b1;
      busy_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      csn_q  <= csn_d;
      busy_q <= busy_d;
      ovr_q  <= ovr_d;
    end
  end
  assign sclk_o    = sclk_q;
  assign mosi_o    = mosi_q;
  assign csN_o     = csn_q;
  assign busy_o    = busy_q;
  assign overrun_o = ovr_q;
endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: directed checks of dac_spi_tx framing, isolation, enable, overrun and async reset
module tb_dac_spi_tx;
`ifdef DAC_SPI_CMD_EN
  localparam int F = 12;
`else
  localparam int F = 8;
`endif
  localparam int LOW  = (2 * F + 1) * 2;
  localparam int BUSY = LOW + 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_ovr = 1'b1;
  logic [7:0] dac = 8'hA5;
  logic en = 1'b1;
  logic sclk_o, mosi_o, csN_o, busy_o, overrun_o;
  logic o_sclk, o_mosi, o_csn, o_busy, o_ovr;
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0, o_falls = 0, o_last = 0, o_gap = 0, o_low = 0, o_nb = 0;
  int o_frames = 0, o_bad = 0, o_run = 0, o_maxrun = 0, o_pulses = 0, m_ovr = 0;
  logic [15:0] o_bits = '0;
  logic o_csn_p = 1'b1, o_sclk_p = 1'b0;
  always #5 clk = ~clk;
  dac_spi_tx #(.N(8), .CLK_DIV(2), .SAMPLE_DIV(64)) u_dut (
    .clk(clk), .rst(rst), .dacCount_i(dac), .enable_i(en),
    .sclk_o(sclk_o), .mosi_o(mosi_o), .csN_o(csN_o), .busy_o(busy_o), .overrun_o(overrun_o)
  );
  dac_spi_tx #(.N(8), .CLK_DIV(2), .SAMPLE_DIV(30)) u_ovr (
    .clk(clk), .rst(rst_ovr), .dacCount_i(8'h5A), .enable_i(1'b1),
    .sclk_o(o_sclk), .mosi_o(o_mosi), .csN_o(o_csn), .busy_o(o_busy), .overrun_o(o_ovr)
  );
  function automatic logic [15:0] frm(input logic [7:0] d);
`ifdef DAC_SPI_CMD_EN
    return {4'h0, 4'b0111, d};
`else
    return {8'h00, d};
`endif
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run_frame(input logic [7:0] mid_val, input logic mid_en,
                           output int low, output int rises, output logic [15:0] bits, output int busy_n);
    int w = 0;
    int mbad = 0;
    logic ps = 1'b0;
    low = 0; rises = 0; bits = '0; busy_n = 0;
    while (busy_o !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("frame_start", w < 200, 1);
    while (busy_o === 1'b1 && busy_n < 500) begin
      busy_n++;
      if (!csN_o) low++;
      else if (mosi_o) mbad++;
      if (sclk_o && !ps) begin
        rises++;
        bits = {bits[14:0], mosi_o};
      end
      ps = sclk_o;
      if (busy_n == 10) begin
        dac = mid_val;
        en  = mid_en;
      end
      @(negedge clk);
    end
    check("mosi_idle", mbad, 0);
  endtask
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (overrun_o) m_ovr++;
      if (o_csn_p && !o_csn) begin
        o_falls++;
        if (o_falls == 2) o_gap = cyc - o_last;
        o_last = cyc; o_bits = '0; o_nb = 0; o_low = 0;
      end
      if (!o_csn) begin
        o_low++;
        if (o_sclk && !o_sclk_p) begin
          o_bits = {o_bits[14:0], o_mosi};
          o_nb++;
        end
      end
      if (!o_csn_p && o_csn) begin
        o_frames++;
        if (o_nb != F || o_bits != frm(8'h5A) || o_low != LOW) o_bad++;
      end
      if (o_ovr) o_run++;
      else if (o_run > 0) begin
        o_pulses++;
        if (o_run > o_maxrun) o_maxrun = o_run;
        o_run = 0;
      end
      o_csn_p = o_csn;
      o_sclk_p = o_sclk;
    end
  end
  initial begin
    int n, low, rises, busy_n, cnt_low, cnt_rise, cnt_ovr;
    logic [15:0] bits;
    logic ps;
    #7;
    check("rst_csn", csN_o, 1);
    check("rst_sclk", sclk_o, 0);
    check("rst_mosi", mosi_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_ovr", overrun_o, 0);
    @(negedge clk);
    rst = 1'b0;
    rst_ovr = 1'b0;
    n = 0;
    while (csN_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("first_tick", n, 64);
    run_frame(8'hA5, 1'b1, low, rises, bits, busy_n);
    check("basic_csn_low", low, LOW);
    check("basic_rises", rises, F);
    check("basic_bits", bits, frm(8'hA5));
    check("basic_busy", busy_n, BUSY);
    run_frame(8'h3C, 1'b1, low, rises, bits, busy_n);
    check("iso_inflight", bits, frm(8'hA5));
    run_frame(8'h3C, 1'b1, low, rises, bits, busy_n);
    check("iso_next", bits, frm(8'h3C));
    check("iso_next_rises", rises, F);
    en = 1'b0;
    cnt_low = 0; cnt_rise = 0; cnt_ovr = 0; ps = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (!csN_o) cnt_low++;
      if (sclk_o && !ps) cnt_rise++;
      if (overrun_o) cnt_ovr++;
      ps = sclk_o;
    end
    check("dis_csn", cnt_low, 0);
    check("dis_sclk", cnt_rise, 0);
    check("dis_ovr", cnt_ovr, 0);
    dac = 8'hA5;
    en = 1'b1;
    run_frame(8'hA5, 1'b0, low, rises, bits, busy_n);
    check("drop_en_bits", bits, frm(8'hA5));
    check("drop_en_rises", rises, F);
    check("drop_en_low", low, LOW);
    en = 1'b1;
    n = 0;
    while (csN_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("pre_rst_frame", n < 200, 1);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_csn", csN_o, 1);
    check("arst_sclk", sclk_o, 0);
    check("arst_mosi", mosi_o, 0);
    check("arst_busy", busy_o, 0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (csN_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("arst_first_tick", n, 64);
    run_frame(8'hA5, 1'b1, low, rises, bits, busy_n);
    check("arst_frame", bits, frm(8'hA5));
    check("main_no_ovr", m_ovr, 0);
    check("ovr_seen", o_pulses > 0, 1);
    check("ovr_width", o_maxrun, 1);
    check("ovr_frames", o_frames > 0, 1);
    check("ovr_frame_ok", o_bad, 0);
    check("ovr_tick_dropped", o_gap, 60);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
